// File: rtl/pipe_ctrl_pkg.sv
// Shared types and PIPE encodings for the PHY control handshake controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT_OK,
        WAIT_STATUS,
        DONE
    } ctrlState_t;

    typedef enum logic {
        REQ_RATE  = 1'b0,
        REQ_POWER = 1'b1
    } reqType_t;

    localparam logic [3:0] P0  = 4'h0;
    localparam logic [3:0] P0S = 4'h1;
    localparam logic [3:0] P1  = 4'h2;
    localparam logic [3:0] P2  = 4'h3;

    localparam logic [3:0] GEN1 = 4'd0;
    localparam logic [3:0] GEN2 = 4'd1;
    localparam logic [3:0] GEN3 = 4'd2;
    localparam logic [3:0] GEN4 = 4'd3;
    localparam logic [3:0] GEN5 = 4'd4;

    localparam logic [3:0] PD_RESET = P1;

endpackage

// File: rtl/pipe_phy_ctrl_handshake_if.sv
// LTSSM-facing request/status channel of the PIPE control handshake controller.
interface pipe_phy_ctrl_handshake_if #(
    parameter int LANESNUMBER = 16
);
    import pipe_ctrl_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    reqType_t               req_type;
    logic [3:0]             req_rate;
    logic [4:0]             req_pclkrate;
    logic [3:0]             req_powerdown;
    logic [LANESNUMBER-1:0] lane_mask;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output req_valid, req_type, req_rate, req_pclkrate, req_powerdown, lane_mask,
        input  req_ready, busy, done, err
    );

    modport slave (
        input  req_valid, req_type, req_rate, req_pclkrate, req_powerdown, lane_mask,
        output req_ready, busy, done, err
    );

endinterface

// File: rtl/pipe_phystatus_collector.sv
// Sticky per-lane PhyStatus collector; all_seen is combinational so a pulse on the
// last outstanding lane completes in the same cycle. Held clear outside the wait state.
module pipe_phystatus_collector #(
    parameter int LANESNUMBER = 16
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [LANESNUMBER-1:0] PhyStatus,
    input  logic [LANESNUMBER-1:0] mask,
    output logic                   all_seen
);

    logic [LANESNUMBER-1:0] stickyQ;
    logic [LANESNUMBER-1:0] seenNow;

    assign seenNow  = stickyQ | (PhyStatus & mask);
    assign all_seen = enable && (seenNow == mask);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            stickyQ <= '0;
        end else if (clear) begin
            stickyQ <= '0;
        end else if (enable) begin
            stickyQ <= seenNow;
        end
    end

endmodule

// File: rtl/pipe_phy_ctrl_handshake.sv
// MAC-side PIPE rate/power-state handshake controller: one request at a time, 4-cycle
// minimum accept-to-done. Optional wait timeout under macro PIPE_CTRL_TIMEOUT_EN.
module pipe_phy_ctrl_handshake
    import pipe_ctrl_pkg::*;
#(
    parameter int LANESNUMBER    = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    pipe_phy_ctrl_handshake_if.slave ctl,
    output logic [3:0]               Rate,
    output logic [4:0]               PCLKRate,
    output logic [4*LANESNUMBER-1:0] PowerDown,
    output logic                     PclkChangeAck,
    input  logic                     PclkChangeOk,
    input  logic [LANESNUMBER-1:0]   PhyStatus
);

    ctrlState_t             stateQ;
    logic                   reqReadyQ;
    logic                   busyQ;
    logic                   doneQ;
    logic                   errQ;
    reqType_t               capType;
    logic [3:0]             capRate;
    logic [4:0]             capPclk;
    logic [3:0]             capPd;
    logic [LANESNUMBER-1:0] capMask;
    logic                   allSeen;
    logic                   timedOut;

    assign ctl.req_ready = reqReadyQ;
    assign ctl.busy      = busyQ;
    assign ctl.done      = doneQ;
    assign ctl.err       = errQ;

    pipe_phystatus_collector #(
        .LANESNUMBER(LANESNUMBER)
    ) u_collector (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .clear    (stateQ != WAIT_STATUS),
        .enable   (stateQ == WAIT_STATUS),
        .PhyStatus(PhyStatus),
        .mask     (capMask),
        .all_seen (allSeen)
    );

`ifdef PIPE_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] waitCnt;

    // Counts only while a wait state holds; any transition clears it, so entry starts at zero.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt <= '0;
        end else if ((stateQ == WAIT_OK && !PclkChangeOk) ||
                     (stateQ == WAIT_STATUS && !allSeen)) begin
            waitCnt <= waitCnt + 1'b1;
        end else begin
            waitCnt <= '0;
        end
    end

    assign timedOut = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timedOut = 1'b0;
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            stateQ        <= IDLE;
            reqReadyQ     <= 1'b0;
            busyQ         <= 1'b0;
            doneQ         <= 1'b0;
            errQ          <= 1'b0;
            Rate          <= GEN1;
            PCLKRate      <= '0;
            PowerDown     <= {LANESNUMBER{PD_RESET}};
            PclkChangeAck <= 1'b0;
            capType       <= REQ_RATE;
            capRate       <= '0;
            capPclk       <= '0;
            capPd         <= PD_RESET;
            capMask       <= '0;
        end else begin
            doneQ <= 1'b0;
            errQ  <= 1'b0;
            case (stateQ)
                IDLE: begin
                    reqReadyQ <= 1'b1;
                    busyQ     <= 1'b0;
                    if (ctl.req_valid && reqReadyQ) begin
                        capType   <= ctl.req_type;
                        capRate   <= ctl.req_rate;
                        capPclk   <= ctl.req_pclkrate;
                        capPd     <= ctl.req_powerdown;
                        capMask   <= ctl.lane_mask;
                        reqReadyQ <= 1'b0;
                        busyQ     <= 1'b1;
                        // An empty lane set has nothing to hand-shake with: flag and stay idle.
                        if (ctl.lane_mask == '0) begin
                            errQ <= 1'b1;
                        end else begin
                            stateQ <= APPLY;
                        end
                    end
                end
                APPLY: begin
                    if (capType == REQ_RATE) begin
                        Rate     <= capRate;
                        PCLKRate <= capPclk;
                        stateQ   <= WAIT_OK;
                    end else begin
                        for (int i = 0; i < LANESNUMBER; i++) begin
                            if (capMask[i]) begin
                                PowerDown[4*i +: 4] <= capPd;
                            end
                        end
                        stateQ <= WAIT_STATUS;
                    end
                end
                WAIT_OK: begin
                    if (PclkChangeOk) begin
                        PclkChangeAck <= 1'b1;
                        stateQ        <= WAIT_STATUS;
                    end else if (timedOut) begin
                        errQ   <= 1'b1;
                        busyQ  <= 1'b0;
                        stateQ <= IDLE;
                    end
                end
                WAIT_STATUS: begin
                    if (allSeen) begin
                        doneQ         <= 1'b1;
                        PclkChangeAck <= 1'b0;
                        busyQ         <= 1'b0;
                        stateQ        <= DONE;
                    end else if (timedOut) begin
                        errQ          <= 1'b1;
                        PclkChangeAck <= 1'b0;
                        busyQ         <= 1'b0;
                        stateQ        <= IDLE;
                    end
                end
                DONE: begin
                    reqReadyQ <= 1'b1;
                    stateQ    <= IDLE;
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_phy_ctrl_handshake.sv
// Directed plus randomized bench for pipe_phy_ctrl_handshake against a cycle-count model
// derived from the handshake rules (accept, apply, ok wait, status collection, done).
module tb_pipe_phy_ctrl_handshake;
    import pipe_ctrl_pkg::*;

    localparam int LN = 16;
`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 4096;
`endif

    logic            CLK = 1'b0;
    logic            reset_n = 1'b0;
    logic [3:0]      Rate;
    logic [4:0]      PCLKRate;
    logic [4*LN-1:0] PowerDown;
    logic            PclkChangeAck;
    logic            PclkChangeOk = 1'b0;
    logic [LN-1:0]   PhyStatus = '0;

    always #5 CLK = ~CLK;

    pipe_phy_ctrl_handshake_if #(.LANESNUMBER(LN)) bus ();

    pipe_phy_ctrl_handshake #(
        .LANESNUMBER   (LN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .ctl          (bus),
        .Rate         (Rate),
        .PCLKRate     (PCLKRate),
        .PowerDown    (PowerDown),
        .PclkChangeAck(PclkChangeAck),
        .PclkChangeOk (PclkChangeOk),
        .PhyStatus    (PhyStatus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference state of the PIPE outputs as the link should see them.
    logic [3:0] curRate;
    logic [4:0] curPclk;
    logic [3:0] curPd[LN];
    int         pA[LN];
    int         pB[LN];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*LN-1:0] pdVec();
        logic [4*LN-1:0] r;
        for (int i = 0; i < LN; i++) r[4*i +: 4] = curPd[i];
        return r;
    endfunction

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic modelReset();
        curRate = GEN1;
        curPclk = 5'd0;
        for (int i = 0; i < LN; i++) curPd[i] = P1;
    endtask

    task automatic clearPulses();
        for (int i = 0; i < LN; i++) begin
            pA[i] = -1;
            pB[i] = -1;
        end
    endtask

    // Caller is positioned in a cycle where req_ready should be 1 (cycle 0 = accept cycle).
    task automatic runTxn(input string tag, input reqType_t ty, input logic [LN-1:0] mask,
                          input logic [3:0] rt, input logic [4:0] pr, input logic [3:0] pd,
                          input int okAt, input bit junk);
        int s;
        int c;
        int first;
        s = (ty == REQ_RATE) ? okAt + 1 : 2;
        c = s;
        for (int i = 0; i < LN; i++) begin
            if (mask[i]) begin
                first = 1000;
                if (pA[i] >= s && pA[i] < first) first = pA[i];
                if (pB[i] >= s && pB[i] < first) first = pB[i];
                if (first > c) c = first;
            end
        end
        chk($sformatf("%s.ready@0", tag), bus.req_ready, 1);
        bus.req_valid     = 1'b1;
        bus.req_type      = ty;
        bus.lane_mask     = mask;
        bus.req_rate      = rt;
        bus.req_pclkrate  = pr;
        bus.req_powerdown = pd;
        for (int t = 1; t <= c + 2; t++) begin
            stepCycle();
            bus.req_valid = (junk && t < c + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (junk) begin
                bus.req_rate      = 4'($urandom);
                bus.req_pclkrate  = 5'($urandom);
                bus.req_powerdown = 4'($urandom);
                bus.lane_mask     = LN'($urandom);
                bus.req_type      = $urandom_range(0, 1) ? REQ_POWER : REQ_RATE;
            end
            PclkChangeOk = (t == okAt) || (junk && t > okAt && $urandom_range(0, 1) == 1);
            for (int i = 0; i < LN; i++)
                PhyStatus[i] = (pA[i] == t) || (pB[i] == t) ||
                               (junk && !mask[i] && $urandom_range(0, 3) == 0);
            if (t == 2) begin
                if (ty == REQ_RATE) begin
                    curRate = rt;
                    curPclk = pr;
                end else begin
                    for (int i = 0; i < LN; i++) if (mask[i]) curPd[i] = pd;
                end
            end
            chk($sformatf("%s.done@%0d", tag, t), bus.done, (t == c + 1));
            chk($sformatf("%s.err@%0d", tag, t), bus.err, 0);
            chk($sformatf("%s.busy@%0d", tag, t), bus.busy, (t <= c));
            chk($sformatf("%s.ready@%0d", tag, t), bus.req_ready, (t == c + 2));
            chk($sformatf("%s.ack@%0d", tag, t), PclkChangeAck,
                (ty == REQ_RATE) && (t > okAt) && (t <= c));
            chk($sformatf("%s.rate@%0d", tag, t), Rate, curRate);
            chk($sformatf("%s.pclk@%0d", tag, t), PCLKRate, curPclk);
            chk($sformatf("%s.pd@%0d", tag, t), PowerDown, pdVec());
        end
        PclkChangeOk = 1'b0;
        PhyStatus    = '0;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        reqType_t      ty;
        logic [LN-1:0] mask;
        int            okAt;
        int            s;

        bus.req_valid     = 1'b0;
        bus.req_type      = REQ_RATE;
        bus.req_rate      = '0;
        bus.req_pclkrate  = '0;
        bus.req_powerdown = '0;
        bus.lane_mask     = '0;
        modelReset();

        repeat (3) @(posedge CLK);
        #1;
        chk("rst.rate", Rate, 0);
        chk("rst.pclk", PCLKRate, 0);
        chk("rst.pd", PowerDown, pdVec());
        chk("rst.ack", PclkChangeAck, 0);
        chk("rst.ready", bus.req_ready, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.err", bus.err, 0);
        #3 reset_n = 1'b1;
        stepCycle();

        // Full-width rate change, Ok at +3, all lanes report at +6.
        clearPulses();
        for (int i = 0; i < LN; i++) pB[i] = 6;
        runTxn("rate16", REQ_RATE, 16'hFFFF, GEN3, 5'h2, P0, 3, 1'b0);

        // Power change to P0 on lanes 0-3, status split across two cycles.
        clearPulses();
        pB[0] = 2; pB[1] = 2; pB[2] = 5; pB[3] = 5;
        runTxn("pwrP0", REQ_POWER, 16'h000F, GEN1, 5'h0, P0, -1, 1'b0);

        // Lane-3 status arriving while still waiting for Ok must not count.
        clearPulses();
        pA[3] = 2; pB[3] = 5;
        runTxn("early", REQ_RATE, 16'h0008, GEN5, 5'h4, P0, 2, 1'b0);

        // Re-requesting the current rate still runs the full handshake.
        clearPulses();
        for (int i = 0; i < LN; i++) pB[i] = 4;
        runTxn("same", REQ_RATE, 16'hFFFF, GEN5, 5'h4, P0, 2, 1'b0);

        // Empty lane mask: one err pulse, nothing applied.
        chk("zero.ready@0", bus.req_ready, 1);
        bus.req_valid     = 1'b1;
        bus.req_type      = REQ_POWER;
        bus.lane_mask     = '0;
        bus.req_powerdown = P2;
        stepCycle();
        bus.req_valid = 1'b0;
        chk("zero.err@1", bus.err, 1);
        chk("zero.ready@1", bus.req_ready, 0);
        chk("zero.busy@1", bus.busy, 1);
        chk("zero.done@1", bus.done, 0);
        chk("zero.pd@1", PowerDown, pdVec());
        chk("zero.rate@1", Rate, curRate);
        stepCycle();
        chk("zero.err@2", bus.err, 0);
        chk("zero.ready@2", bus.req_ready, 1);
        chk("zero.pd@2", PowerDown, pdVec());

        // Randomized requests with noise on unused inputs and ignored req_valid while busy.
        for (int n = 0; n < 24; n++) begin
            ty   = $urandom_range(0, 1) ? REQ_POWER : REQ_RATE;
            mask = LN'($urandom_range(1, 16'hFFFF));
            okAt = $urandom_range(2, 6);
            s    = (ty == REQ_RATE) ? okAt + 1 : 2;
            for (int i = 0; i < LN; i++) begin
                pA[i] = $urandom_range(0, s + 4);
                pB[i] = s + $urandom_range(0, 4);
            end
            runTxn($sformatf("rnd%0d", n), ty, mask, 4'($urandom_range(0, 4)),
                   5'($urandom), 4'($urandom_range(0, 3)), okAt, 1'b1);
        end

        // Reset pulled while waiting for PhyStatus.
        chk("arst.ready@0", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_type     = REQ_RATE;
        bus.lane_mask    = 16'hFFFF;
        bus.req_rate     = GEN4;
        bus.req_pclkrate = 5'h7;
        stepCycle();
        bus.req_valid = 1'b0;
        stepCycle();
        PclkChangeOk = 1'b1;
        stepCycle();
        PclkChangeOk = 1'b0;
        chk("arst.ack@3", PclkChangeAck, 1);
        chk("arst.rate@3", Rate, GEN4);
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        chk("arst.ack", PclkChangeAck, 0);
        chk("arst.rate", Rate, curRate);
        chk("arst.pclk", PCLKRate, curPclk);
        chk("arst.pd", PowerDown, pdVec());
        chk("arst.busy", bus.busy, 0);
        chk("arst.ready", bus.req_ready, 0);
        #2 reset_n = 1'b1;
        stepCycle();
        chk("arst.ready.post", bus.req_ready, 1);

`ifdef PIPE_CTRL_TIMEOUT_EN
        // No Ok ever: err after TIMEOUT_CYCLES in WAIT_OK, applied rate held.
        chk("tmo.ready@0", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_type     = REQ_RATE;
        bus.lane_mask    = 16'hFFFF;
        bus.req_rate     = GEN4;
        bus.req_pclkrate = 5'h3;
        for (int t = 1; t <= 11; t++) begin
            stepCycle();
            bus.req_valid = 1'b0;
            if (t == 2) begin
                curRate = GEN4;
                curPclk = 5'h3;
            end
            chk($sformatf("tmo.err@%0d", t), bus.err, (t == 10));
            chk($sformatf("tmo.done@%0d", t), bus.done, 0);
            chk($sformatf("tmo.ack@%0d", t), PclkChangeAck, 0);
            chk($sformatf("tmo.rate@%0d", t), Rate, curRate);
            chk($sformatf("tmo.ready@%0d", t), bus.req_ready, (t == 11));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_phy_ctrl_handshake.md
Name: pipe_phy_ctrl_handshake

Overview:
- Parametrised MAC-side controller for PIPE PHY control handshakes on an N-lane link: rate/PCLK-rate changes (PclkChangeOk/PclkChangeAck/PhyStatus) and power-state changes (PowerDown/PhyStatus).
- Sits between the LTSSM and the PIPE interface signals.
- Accepts one request at a time, drives Rate/PCLKRate/PowerDown, aggregates per-lane PhyStatus over the active lanes, and reports done/error.

Parameters:
LANESNUMBER, 16, number of PIPE lanes
TIMEOUT_CYCLES, 4096, wait-state timeout in CLK cycles (used only with the optional feature)
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
CLK  input  1  PIPE clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request strobe
req_ready  output  1  controller idle, accepts request
req_type  input  1  0 = rate change, 1 = power change
req_rate  input  4  requested Rate
req_pclkrate  input  5  requested PCLKRate
req_powerdown  input  4  requested PowerDown state, applied to masked lanes
lane_mask  input  LANESNUMBER  active lanes for this request
Rate  output  4  PIPE Rate
PCLKRate  output  5  PIPE PCLKRate
PowerDown  output  4*LANESNUMBER  PIPE PowerDown, 4 bits per lane
PclkChangeAck  output  1  MAC acknowledge of PCLK change
PclkChangeOk  input  1  PHY ready for PCLK change
PhyStatus  input  LANESNUMBER  per-lane PHY completion pulse
busy  output  1  handshake in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse

Behaviour:
- Interface: one clock CLK; reset_n is asynchronous, active-low. All outputs are registered.
- Reset values: Rate=0, PCLKRate=0, PowerDown=4'b0010 (P1) on every lane, PclkChangeAck=0, req_ready=0, busy=0, done=0, err=0, state IDLE. req_ready=1 from the first clock edge after reset deassertion.
- Accept: req_valid && req_ready at an edge captures req_* and lane_mask. The next cycle has req_ready=0 and busy=1.
- Zero lane_mask: request is accepted, err pulses the next cycle, no outputs change, FSM returns to IDLE.
- States: IDLE, APPLY, WAIT_OK, WAIT_STATUS, DONE.
- APPLY, 1 cycle:
  - Rate change: Rate and PCLKRate load the captured values.
  - Power change: PowerDown lanes with mask=1 load req_powerdown; masked-out lanes keep their previous value.
  - Next state: WAIT_OK for rate, WAIT_STATUS for power.
- WAIT_OK:
  - Wait for PclkChangeOk=1.
  - On the sample, PclkChangeAck=1 from the next cycle, then enter WAIT_STATUS.
- WAIT_STATUS:
  - Sticky register collects PhyStatus & mask. It is cleared on entry; pulses outside this state are ignored.
  - Completion when (sticky | (PhyStatus & mask)) == mask, so a same-cycle pulse on the last lane counts.
  - On completion go to DONE.
- DONE, 1 cycle: done=1, PclkChangeAck=0, busy=0, then IDLE with req_ready=1. Minimum rate-change latency from accept to done is 4 cycles.
- Same value requested as current: full handshake still performed.
- PclkChangeOk dropping in WAIT_STATUS: ignored.
- reset_n asserted mid-operation: all outputs return to reset values immediately; the in-flight request is lost.
- req_valid while busy: ignored, not queued.

Optional Feature:
- Macro PIPE_CTRL_TIMEOUT_EN.
- Defined:
  - Counter runs in WAIT_OK and WAIT_STATUS; it is cleared on entry to each state.
  - On reaching TIMEOUT_CYCLES: err pulses 1 cycle, PclkChangeAck=0, Rate/PCLKRate/PowerDown keep the applied values, FSM goes to IDLE, done is not pulsed.
- Undefined: no counter; waits indefinitely; err is driven only by the zero-mask case.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum
  - req_type enum (REQ_RATE, REQ_POWER)
  - PowerDown encodings P0=4'h0, P0S=4'h1, P1=4'h2, P2=4'h3
  - Rate encodings GEN1..GEN5 = 0..4
  - reset PowerDown constant
- Sub-module pipe_phystatus_collector:
  - inputs: clear, enable, PhyStatus, mask
  - output: all_seen
  - contains the sticky register and completion compare

Test Plan:
- Rate change, LANESNUMBER=16, mask=16'hFFFF, req_rate=2, req_pclkrate=5'h2, PclkChangeOk at +3, PhyStatus all lanes at +6 -> Rate=2 at cycle 2, Ack high from cycle after Ok until DONE, done single pulse, Ack=0 with done.
- Power change to P0, mask=16'h000F, PhyStatus lanes 0-1 at +2 and lanes 2-3 at +5 -> PowerDown[15:0]=16'h0000, upper lanes stay 4'h2, done the cycle after lanes 2-3 pulse.
- PhyStatus pulse on lane 3 in WAIT_OK, before Ack -> ignored; completion only after a later lane-3 pulse.
- lane_mask=0 -> err pulses once, Rate/PowerDown unchanged, req_ready=1 two cycles after accept.
- PIPE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, PclkChangeOk never asserted -> err pulse 8 cycles after entering WAIT_OK, no done, Rate holds the new value, Ack stays 0.
- reset_n low during WAIT_STATUS -> PclkChangeAck=0, Rate=0, PowerDown all 4'h2 asynchronously; req_ready=1 after release.
